tcp_snd_sched: RTL and testbench
================================

// Module: tcp_snd_sched
// PURPOSE
//   Sender-side window scheduler for the established TCP connection. Decides each cycle whether to
//   emit a segment (seq, len) into the forward network. Tracks receiver ACKs and advertised window
//   returned by the reverse network. Recovers from dropped/reordered traffic: go-back-N retransmit
//   on timeout, 1-byte zero-window probe.
// PARAMETERS
//   SEQ_W     4   width of sequence numbers, lengths, windows (all arithmetic mod 2^SEQ_W)
//   MAX_SEG   4   maximum segment length emitted
//   INIT_WND  4   receiver window assumed after reset
//   RTO       12  retransmit/persist timeout in cycles (1..2^TMR_W-1)
//   TMR_W     4   timer width
// PORTS
//   clk       in   1      single clock, rising edge
//   reset     in   1      asynchronous, active-high
//   rcv_ack   in   1      ACK valid from reverse network (single-cycle)
//   rcv_seq   in   SEQ_W  ACK number: next byte receiver expects
//   rcv_buff  in   SEQ_W  receiver advertised window
//   usr_end   in   SEQ_W  one past last byte queued by sending user
//   seg_val   out  1      segment valid, one-cycle pulse, registered
//   seg_seq   out  SEQ_W  first sequence number of segment
//   seg_len   out  SEQ_W  segment length, 1..MAX_SEG when seg_val
//   snd_una   out  SEQ_W  oldest unacknowledged byte
//   snd_nxt   out  SEQ_W  next byte to send
//   retx      out  1      pulses with seg_val when segment is a retransmit or probe
// BEHAVIOUR
//   Reset: seg_val=0, seg_seq=0, seg_len=0, retx=0, snd_una=0, snd_nxt=0, wnd=INIT_WND, timer stopped,
//     state IDLE. Asserting reset mid-operation discards all in-flight state.
//   Derived (mod 2^SEQ_W, from registered state): flight=snd_nxt-snd_una; pend=usr_end-snd_nxt;
//     usable=(wnd>flight)?wnd-flight:0; len=min(pend,usable,MAX_SEG).
//   Environment rule: usr_end-snd_una <= 2^(SEQ_W-1); design need not handle violation.
//   ACK acceptance: accepted iff (rcv_seq-snd_una) <= flight; else ignored entirely (stale/dup-late).
//     Accepted: snd_una<=rcv_seq, wnd<=rcv_buff next cycle. Timer restarts at RTO if bytes
//     remain in flight, else stops.
//   States:
//     IDLE : flight=0, pend=0. -> SEND when pend>0.
//     SEND : if len>0: seg_val=1, seg_seq=snd_nxt, seg_len=len, snd_nxt+=len. Timer starts if stopped.
//            if len=0: -> WAIT. If pend=0 and flight=0 -> IDLE.
//     WAIT : no emission. -> SEND when usable>0 and pend>0. Timer expiry ->
//            RETX if flight>0; PROBE if flight=0 and wnd=0.
//     RETX : one cycle. snd_nxt<=snd_una, timer reloaded, -> SEND; next segment has retx=1.
//     PROBE: emit seg_seq=snd_una, seg_len=1, retx=1. snd_nxt unchanged. Timer reloaded, -> WAIT.
//   Timer: down-counter, loaded with RTO, decrements every cycle while running; expiry = reaches 0.
//   Latency: decision in state cycle, seg_val visible after next rising edge. Max one segment/cycle.
//   Simultaneous events, same cycle:
//     - ACK + emission: both take effect. snd_nxt advances. snd_una/wnd update.
//       Emission uses pre-ACK values.
//     - ACK + timer expiry: accepted ACK wins, no RETX/PROBE.
//     - Ignored ACK + expiry: expiry acts.
//   Wrap-around: all compares via modular differences. snd_nxt/snd_una roll 15->0 transparently.
//   wnd shrink below flight: usable=0, no emission, nothing reclaimed.
// TESTING
//   1 Reset, usr_end=6, wnd=4 -> seg(0,4) next cycle, then WAIT. ACK(4,4) -> seg(4,2). ACK(6,4) -> IDLE.
//   2 usr_end=3, no ACK for RTO cycles -> RETX, then seg(0,3) retx=1. Timer restarted.
//   3 snd_una=14, usr_end=2 (wrap), wnd=4 -> seg(14,4) with snd_nxt=2. ACK(2,4) accepted, snd_una=2.
//   4 In flight 0..3, ACK rcv_seq=8 (outside flight) -> ignored. Timer keeps counting, snd_una=0.
//   5 ACK(4,0), pend=2 -> no emission. After RTO -> probe seg(4,1) retx=1. ACK(5,3) -> seg(5,1).
//   6 Timer expiry same cycle as valid ACK -> no retransmit. Reset mid-SEND -> all outputs 0 next edge.

Source files
------------

// File: rtl/tcp_snd_sched_if.sv
// Segment/ACK signal bundle between the TCP send scheduler and its environment.
// The slave side is the scheduler; the master side drives ACKs and the user queue end.
interface tcp_snd_sched_if #(
    parameter int SEQ_W = 4
);
    logic             rcv_ack;
    logic [SEQ_W-1:0] rcv_seq;
    logic [SEQ_W-1:0] rcv_buff;
    logic [SEQ_W-1:0] usr_end;
    logic             seg_val;
    logic [SEQ_W-1:0] seg_seq;
    logic [SEQ_W-1:0] seg_len;
    logic [SEQ_W-1:0] snd_una;
    logic [SEQ_W-1:0] snd_nxt;
    logic             retx;

    modport master (
        output rcv_ack, rcv_seq, rcv_buff, usr_end,
        input  seg_val, seg_seq, seg_len, snd_una, snd_nxt, retx
    );

    modport slave (
        input  rcv_ack, rcv_seq, rcv_buff, usr_end,
        output seg_val, seg_seq, seg_len, snd_una, snd_nxt, retx
    );
endinterface

// File: rtl/tcp_snd_sched.sv
// Sender-side TCP window scheduler: emits (seq,len) segments within the peer window,
// tracks ACKs, go-back-N retransmits on timeout and sends 1-byte zero-window probes.
module tcp_snd_sched #(
    parameter int SEQ_W    = 4,
    parameter int MAX_SEG  = 4,
    parameter int INIT_WND = 4,
    parameter int RTO      = 12,
    parameter int TMR_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    tcp_snd_sched_if.slave sif
);
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RETX, S_PROBE} state_t;
    typedef logic [SEQ_W-1:0] seq_t;

    localparam seq_t             C_MAX_SEG  = seq_t'(MAX_SEG);
    localparam seq_t             C_INIT_WND = seq_t'(INIT_WND);
    localparam logic [TMR_W-1:0] C_RTO      = TMR_W'(RTO);

    function automatic seq_t min_seq(input seq_t a, input seq_t b);
        return (a < b) ? a : b;
    endfunction

    state_t           r_state, w_state_d;
    seq_t             r_una, r_nxt, r_wnd, r_seg_seq, r_seg_len;
    logic             r_seg_val, r_retx, r_retx_pend, r_probe, r_tmr_run;
    logic [TMR_W-1:0] r_tmr;

    seq_t             w_una_d, w_nxt_d, w_wnd_d, w_seg_seq_d, w_seg_len_d;
    logic             w_seg_val_d, w_retx_d, w_retx_pend_d, w_probe_d, w_tmr_run_d;
    logic [TMR_W-1:0] w_tmr_d;

    seq_t w_flight, w_pend, w_usable, w_len, w_ack_diff;
    logic w_ack_ok, w_exp;

    assign w_flight   = r_nxt - r_una;
    assign w_pend     = sif.usr_end - r_nxt;
    assign w_usable   = (r_wnd > w_flight) ? (r_wnd - w_flight) : '0;
    assign w_len      = min_seq(min_seq(w_pend, w_usable), C_MAX_SEG);
    assign w_ack_diff = sif.rcv_seq - r_una;
    // An outstanding probe byte is not counted in snd_nxt, so its ACK lands one past flight.
    assign w_ack_ok   = sif.rcv_ack && (w_ack_diff <= (w_flight + seq_t'(r_probe)));
    assign w_exp      = r_tmr_run && (r_tmr == '0);

    always_comb begin
        w_state_d     = r_state;
        w_una_d       = r_una;
        w_nxt_d       = r_nxt;
        w_wnd_d       = r_wnd;
        w_seg_val_d   = 1'b0;
        w_seg_seq_d   = r_seg_seq;
        w_seg_len_d   = r_seg_len;
        w_retx_d      = 1'b0;
        w_retx_pend_d = r_retx_pend;
        w_probe_d     = r_probe;
        w_tmr_run_d   = r_tmr_run;
        w_tmr_d       = (r_tmr_run && (r_tmr != '0)) ? (r_tmr - TMR_W'(1)) : r_tmr;

        unique case (r_state)
            S_IDLE: begin
                if (w_pend != '0) w_state_d = S_SEND;
            end
            S_SEND: begin
                if (w_len != '0) begin
                    w_seg_val_d   = 1'b1;
                    w_seg_seq_d   = r_nxt;
                    w_seg_len_d   = w_len;
                    w_retx_d      = r_retx_pend;
                    w_retx_pend_d = 1'b0;
                    w_nxt_d       = r_nxt + w_len;
                    if (!r_tmr_run) begin
                        w_tmr_d     = C_RTO;
                        w_tmr_run_d = 1'b1;
                    end
                end else if ((w_pend == '0) && (w_flight == '0)) begin
                    w_state_d = S_IDLE;
                end else begin
                    w_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An accepted ACK in the same cycle suppresses the timeout action.
                if (!w_ack_ok && w_exp) begin
                    if (w_flight != '0)      w_state_d = S_RETX;
                    else if (r_wnd == '0)    w_state_d = S_PROBE;
                    else                     w_tmr_run_d = 1'b0;
                end else if ((w_pend == '0) && (w_flight == '0)) begin
                    w_state_d = S_IDLE;
                end else if ((w_usable != '0) && (w_pend != '0)) begin
                    w_state_d = S_SEND;
                end else if (!r_tmr_run && (w_flight == '0) && (r_wnd == '0) && (w_pend != '0)) begin
                    w_tmr_d     = C_RTO;
                    w_tmr_run_d = 1'b1;
                end
            end
            S_RETX: begin
                w_nxt_d       = w_ack_ok ? sif.rcv_seq : r_una;
                w_retx_pend_d = 1'b1;
                w_probe_d     = 1'b0;
                w_tmr_d       = C_RTO;
                w_tmr_run_d   = 1'b1;
                w_state_d     = S_SEND;
            end
            S_PROBE: begin
                w_seg_val_d = 1'b1;
                w_seg_seq_d = r_una;
                w_seg_len_d = seq_t'(1);
                w_retx_d    = 1'b1;
                w_probe_d   = 1'b1;
                w_tmr_d     = C_RTO;
                w_tmr_run_d = 1'b1;
                w_state_d   = S_WAIT;
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_ack_ok) begin
            w_una_d   = sif.rcv_seq;
            w_wnd_d   = sif.rcv_buff;
            w_probe_d = 1'b0;
            if (w_ack_diff > w_flight) w_nxt_d = sif.rcv_seq;
            if ((w_nxt_d - sif.rcv_seq) != '0) begin
                w_tmr_d     = C_RTO;
                w_tmr_run_d = 1'b1;
            end else begin
                w_tmr_run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_una       <= '0;
            r_nxt       <= '0;
            r_wnd       <= C_INIT_WND;
            r_seg_val   <= 1'b0;
            r_seg_seq   <= '0;
            r_seg_len   <= '0;
            r_retx      <= 1'b0;
            r_retx_pend <= 1'b0;
            r_probe     <= 1'b0;
            r_tmr_run   <= 1'b0;
            r_tmr       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_una       <= w_una_d;
            r_nxt       <= w_nxt_d;
            r_wnd       <= w_wnd_d;
            r_seg_val   <= w_seg_val_d;
            r_seg_seq   <= w_seg_seq_d;
            r_seg_len   <= w_seg_len_d;
            r_retx      <= w_retx_d;
            r_retx_pend <= w_retx_pend_d;
            r_probe     <= w_probe_d;
            r_tmr_run   <= w_tmr_run_d;
            r_tmr       <= w_tmr_d;
        end
    end

    assign sif.seg_val = r_seg_val;
    assign sif.seg_seq = r_seg_seq;
    assign sif.seg_len = r_seg_len;
    assign sif.snd_una = r_una;
    assign sif.snd_nxt = r_nxt;
    assign sif.retx    = r_retx;
endmodule

// File: tb/tb_tcp_snd_sched.sv
// Directed bench for tcp_snd_sched: a per-cycle vector table for normal/wrap traffic,
// plus hand sequences for timeout retransmit, stale ACKs, zero-window probing and reset.
module tb_tcp_snd_sched;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    tcp_snd_sched_if #(.SEQ_W(4)) bus ();

    tcp_snd_sched #(
        .SEQ_W(4), .MAX_SEG(4), .INIT_WND(4), .RTO(12), .TMR_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    typedef struct {
        logic       ack;
        logic [3:0] rseq;
        logic [3:0] rbuf;
        logic [3:0] uend;
        logic       val;
        logic [3:0] seq;
        logic [3:0] len;
        logic       rtx;
        logic [3:0] una;
        logic [3:0] nxt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input int ack, input int rseq, input int rbuf, input int uend,
                                input int val, input int seq, input int len, input int rtx,
                                input int una, input int nxt);
        vec_t v;
        v.ack  = 1'(ack);
        v.rseq = 4'(rseq);
        v.rbuf = 4'(rbuf);
        v.uend = 4'(uend);
        v.val  = 1'(val);
        v.seq  = 4'(seq);
        v.len  = 4'(len);
        v.rtx  = 1'(rtx);
        v.una  = 4'(una);
        v.nxt  = 4'(nxt);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.rcv_ack  = 1'b0;
        bus.rcv_seq  = '0;
        bus.rcv_buff = '0;
        bus.usr_end  = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic send_ack(input int seq, input int buff);
        bus.rcv_ack  = 1'b1;
        bus.rcv_seq  = 4'(seq);
        bus.rcv_buff = 4'(buff);
        tick();
        bus.rcv_ack  = 1'b0;
    endtask

    // Returns the number of rising edges until seg_val is seen.
    task automatic wait_seg(input string name, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.seg_val && n < budget);
        checks++;
        if (!bus.seg_val) begin
            failures++;
            $display("FAIL %s no segment within %0d cycles", name, n);
        end
    endtask

    task automatic chk_seg(input string name, input int seq, input int len, input int rtx);
        chk({name, "_seq"},  int'(bus.seg_seq), seq);
        chk({name, "_len"},  int'(bus.seg_len), len);
        chk({name, "_retx"}, int'(bus.retx), rtx);
    endtask

    initial begin
        int n;
        int seen;

        // ack rseq rbuf uend | val seq len rtx una nxt
        tbl[0]  = mk(0,  0, 0,  6,  0,  0, 0, 0,  0,  0);
        tbl[1]  = mk(0,  0, 0,  6,  1,  0, 4, 0,  0,  4);
        tbl[2]  = mk(0,  0, 0,  6,  0,  0, 0, 0,  0,  4);
        tbl[3]  = mk(1,  4, 4,  6,  0,  0, 0, 0,  4,  4);
        tbl[4]  = mk(0,  0, 0,  6,  0,  0, 0, 0,  4,  4);
        tbl[5]  = mk(0,  0, 0,  6,  1,  4, 2, 0,  4,  6);
        tbl[6]  = mk(0,  0, 0,  6,  0,  0, 0, 0,  4,  6);
        tbl[7]  = mk(1,  6, 4,  6,  0,  0, 0, 0,  6,  6);
        tbl[8]  = mk(0,  0, 0,  6,  0,  0, 0, 0,  6,  6);
        tbl[9]  = mk(0,  0, 0, 10,  0,  0, 0, 0,  6,  6);
        tbl[10] = mk(0,  0, 0, 10,  1,  6, 4, 0,  6, 10);
        tbl[11] = mk(0,  0, 0, 10,  0,  0, 0, 0,  6, 10);
        tbl[12] = mk(1, 10, 4, 10,  0,  0, 0, 0, 10, 10);
        tbl[13] = mk(0,  0, 0, 14,  0,  0, 0, 0, 10, 10);
        tbl[14] = mk(0,  0, 0, 14,  1, 10, 4, 0, 10, 14);
        tbl[15] = mk(0,  0, 0, 14,  0,  0, 0, 0, 10, 14);
        tbl[16] = mk(1, 14, 4, 14,  0,  0, 0, 0, 14, 14);
        tbl[17] = mk(0,  0, 0,  2,  0,  0, 0, 0, 14, 14);
        tbl[18] = mk(0,  0, 0,  2,  1, 14, 4, 0, 14,  2);
        tbl[19] = mk(0,  0, 0,  2,  0,  0, 0, 0, 14,  2);
        tbl[20] = mk(1,  2, 4,  2,  0,  0, 0, 0,  2,  2);
        tbl[21] = mk(0,  0, 0,  2,  0,  0, 0, 0,  2,  2);

        apply_reset();
        chk("rst_val",  int'(bus.seg_val), 0);
        chk("rst_seq",  int'(bus.seg_seq), 0);
        chk("rst_len",  int'(bus.seg_len), 0);
        chk("rst_retx", int'(bus.retx), 0);
        chk("rst_una",  int'(bus.snd_una), 0);
        chk("rst_nxt",  int'(bus.snd_nxt), 0);

        // Basic send/ACK flow, then walk snd_una up to 14 and across the 15->0 wrap.
        for (int i = 0; i < 22; i++) begin
            bus.rcv_ack  = tbl[i].ack;
            bus.rcv_seq  = tbl[i].rseq;
            bus.rcv_buff = tbl[i].rbuf;
            bus.usr_end  = tbl[i].uend;
            tick();
            chk($sformatf("row%0d_val", i),  int'(bus.seg_val), int'(tbl[i].val));
            chk($sformatf("row%0d_retx", i), int'(bus.retx),    int'(tbl[i].rtx));
            chk($sformatf("row%0d_una", i),  int'(bus.snd_una), int'(tbl[i].una));
            chk($sformatf("row%0d_nxt", i),  int'(bus.snd_nxt), int'(tbl[i].nxt));
            if (tbl[i].val) begin
                chk($sformatf("row%0d_seq", i), int'(bus.seg_seq), int'(tbl[i].seq));
                chk($sformatf("row%0d_len", i), int'(bus.seg_len), int'(tbl[i].len));
            end
        end
        bus.rcv_ack = 1'b0;

        // Timeout go-back-N: first gap is RTO plus the WAIT-expiry, RETX and SEND cycles;
        // the second is one shorter because the timer is reloaded in RETX, not at emission.
        apply_reset();
        bus.usr_end = 4'd3;
        wait_seg("t2_first", 10, n);
        chk_seg("t2_first", 0, 3, 0);
        wait_seg("t2_retx", 40, n);
        chk("t2_retx_gap", n, 15);
        chk_seg("t2_retx", 0, 3, 1);
        chk("t2_retx_nxt", int'(bus.snd_nxt), 3);
        wait_seg("t2_retx2", 40, n);
        chk("t2_retx2_gap", n, 14);
        chk_seg("t2_retx2", 0, 3, 1);

        // ACK outside the flight is ignored and the timer keeps running.
        apply_reset();
        bus.usr_end = 4'd4;
        wait_seg("t4_first", 10, n);
        chk_seg("t4_first", 0, 4, 0);
        tick();
        tick();
        send_ack(8, 4);
        chk("t4_una", int'(bus.snd_una), 0);
        chk("t4_nxt", int'(bus.snd_nxt), 4);
        wait_seg("t4_retx", 40, n);
        chk("t4_retx_gap", n + 3, 15);
        chk_seg("t4_retx", 0, 4, 1);

        // Zero window: persist timer starts the cycle after the ACK, then a 1-byte probe.
        apply_reset();
        bus.usr_end = 4'd6;
        wait_seg("t5_first", 10, n);
        chk_seg("t5_first", 0, 4, 0);
        tick();
        send_ack(4, 0);
        chk("t5_una", int'(bus.snd_una), 4);
        wait_seg("t5_probe", 40, n);
        chk("t5_probe_gap", n, 15);
        chk_seg("t5_probe", 4, 1, 1);
        chk("t5_probe_nxt", int'(bus.snd_nxt), 4);
        send_ack(5, 3);
        chk("t5_ack_una", int'(bus.snd_una), 5);
        chk("t5_ack_nxt", int'(bus.snd_nxt), 5);
        wait_seg("t5_after", 10, n);
        chk("t5_after_gap", n, 2);
        chk_seg("t5_after", 5, 1, 0);
        chk("t5_after_nxt", int'(bus.snd_nxt), 6);

        // Accepted ACK arrives in the very cycle the timer reaches zero.
        apply_reset();
        bus.usr_end = 4'd3;
        wait_seg("t6_first", 10, n);
        chk_seg("t6_first", 0, 3, 0);
        repeat (12) tick();
        send_ack(3, 4);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.seg_val) seen = 1;
            tick();
        end
        chk("t6_no_retx", seen, 0);
        chk("t6_una", int'(bus.snd_una), 3);
        chk("t6_nxt", int'(bus.snd_nxt), 3);

        // Reset asserted while a segment is on the outputs and SEND is active.
        apply_reset();
        bus.usr_end = 4'd8;
        tick();
        tick();
        chk("t7_pre_val", int'(bus.seg_val), 1);
        chk("t7_pre_nxt", int'(bus.snd_nxt), 4);
        #2;
        reset = 1'b1;
        tick();
        chk("t7_rst_val",  int'(bus.seg_val), 0);
        chk("t7_rst_seq",  int'(bus.seg_seq), 0);
        chk("t7_rst_len",  int'(bus.seg_len), 0);
        chk("t7_rst_retx", int'(bus.retx), 0);
        chk("t7_rst_una",  int'(bus.snd_una), 0);
        chk("t7_rst_nxt",  int'(bus.snd_nxt), 0);
        reset = 1'b0;
        wait_seg("t7_restart", 10, n);
        chk("t7_restart_gap", n, 2);
        chk_seg("t7_restart", 0, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
